// File: rtl/mul_fp_pkg.sv
// rtl/mul_fp_pkg.sv - shared encodings and helpers for the FP multiplier back end
// Contents:
//   cls_e          operand / result class codes
//   BIAS, QNAN     exponent bias and canonical quiet NaN
//   FLG_*          bit positions inside the 4-bit flags word
//   resolve_class  folds two operand classes into the special code of the product
package mul_fp_pkg;

  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } cls_e;

  // NaN wins; INF x ZERO is also NaN; otherwise INF dominates ZERO.
  function automatic cls_e resolve_class(input cls_e a, input cls_e b);
    cls_e r;
    r = CLS_NORMAL;
    if (a == CLS_NAN || b == CLS_NAN ||
        (a == CLS_INF && b == CLS_ZERO) || (a == CLS_ZERO && b == CLS_INF))
      r = CLS_NAN;
    else if (a == CLS_INF || b == CLS_INF)
      r = CLS_INF;
    else if (a == CLS_ZERO || b == CLS_ZERO)
      r = CLS_ZERO;
    return r;
  endfunction

endpackage

// File: rtl/mul_round_rne.sv
// rtl/mul_round_rne.sv - round-to-nearest-even of a normalised fraction
// Ports:
//   frac_in   in   MAN_W  normalised fraction (hidden one dropped)
//   g, s      in   1      guard bit and sticky OR of the remaining bits
//   exp_in    in   EW     signed working exponent
//   frac_out  out  MAN_W  rounded fraction
//   exp_out   out  EW     exponent, bumped when rounding carries out
//   inexact   out  1      any discarded bit was set
module mul_round_rne #(
  parameter int MAN_W = 23,
  parameter int EW    = 10
) (
  input  logic [MAN_W-1:0]    frac_in,
  input  logic                g,
  input  logic                s,
  input  logic signed [EW-1:0] exp_in,
  output logic [MAN_W-1:0]    frac_out,
  output logic signed [EW-1:0] exp_out,
  output logic                inexact
);

  logic             up;
  logic [MAN_W:0]   sum;

  assign up  = g & (s | frac_in[0]);
  assign sum = {1'b0, frac_in} + {{MAN_W{1'b0}}, up};

  // On carry-out the low MAN_W bits of sum are already all zero, i.e. 1.0 x 2^(e+1).
  assign frac_out = sum[MAN_W-1:0];
  assign exp_out  = exp_in + $signed({{(EW-1){1'b0}}, sum[MAN_W]});
  assign inexact  = g | s;

endmodule

// File: rtl/mul_norm_round.sv
// rtl/mul_norm_round.sv - FP multiplier final stage: normalise, round, range/special handling
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake
//   mant_prod         PW-bit product of the 1.M mantissas (leading one at PW-1 or PW-2)
//   exp_a, exp_b      biased operand exponents
//   sign_a, sign_b    operand signs
//   class_a, class_b  operand classes (cls_e encoding)
//   out_valid/out_ready downstream handshake
//   result            {sign, exp, frac}
//   flags             {invalid, overflow, underflow, inexact}
module mul_norm_round
  import mul_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*(MAN_W+1)-1:0]     mant_prod,
  input  logic [EXP_W-1:0]           exp_a,
  input  logic [EXP_W-1:0]           exp_b,
  input  logic                       sign_a,
  input  logic                       sign_b,
  input  logic [1:0]                 class_a,
  input  logic [1:0]                 class_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       result,
  output logic [3:0]                 flags
);

  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  // Stage 1 registers
  logic                  s1_valid;
  logic                  s1_sign;
  logic signed [EW-1:0]  s1_exp;
  logic [MAN_W-1:0]      s1_frac;
  logic                  s1_g;
  logic                  s1_s;
  cls_e                  s1_cls;

  // Stage 2 registers drive result/flags directly
  logic                  s2_valid;

  // Held low for one cycle after reset release so nothing is accepted mid-release.
  logic                  rdy_q;
  logic                  s2_adv;

  // Stage 1 combinational capture values
  logic                  top_bit;
  logic signed [EW-1:0]  c1_exp;
  logic [MAN_W-1:0]      c1_frac;
  logic                  c1_g;
  logic                  c1_s;

  assign top_bit = mant_prod[PW-1];
  assign c1_exp  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S
                 + $signed({{(EW-1){1'b0}}, top_bit});

  always_comb begin
    if (top_bit) begin
      c1_frac = mant_prod[PW-2 -: MAN_W];
      c1_g    = mant_prod[PW-2-MAN_W];
      c1_s    = |mant_prod[PW-3-MAN_W:0];
    end else begin
      c1_frac = mant_prod[PW-3 -: MAN_W];
      c1_g    = mant_prod[PW-3-MAN_W];
      c1_s    = |mant_prod[PW-4-MAN_W:0];
    end
  end

  // Stage 2 combinational: rounding, then range and special override
  logic [MAN_W-1:0]      r_frac;
  logic signed [EW-1:0]  r_exp;
  logic                  r_inexact;
  logic [EXP_W+MAN_W:0]  nxt_result;
  logic [3:0]            nxt_flags;

  mul_round_rne #(.MAN_W(MAN_W), .EW(EW)) u_round (
    .frac_in  (s1_frac),
    .g        (s1_g),
    .s        (s1_s),
    .exp_in   (s1_exp),
    .frac_out (r_frac),
    .exp_out  (r_exp),
    .inexact  (r_inexact)
  );

  always_comb begin
    nxt_result = {s1_sign, r_exp[EXP_W-1:0], r_frac};
    nxt_flags  = '0;
    nxt_flags[FLG_INEXACT] = r_inexact;
    case (s1_cls)
      CLS_NAN: begin
        nxt_result = QNAN;
        nxt_flags  = '0;
        nxt_flags[FLG_INVALID] = 1'b1;
      end
      CLS_INF: begin
        nxt_result = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        nxt_flags  = '0;
      end
      CLS_ZERO: begin
        nxt_result = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
        nxt_flags  = '0;
      end
      default: begin
        if (r_exp >= EXP_MAX) begin
          nxt_result = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          nxt_flags  = '0;
          nxt_flags[FLG_OVERFLOW] = 1'b1;
          nxt_flags[FLG_INEXACT]  = 1'b1;
        end else if (r_exp <= 0) begin
          // Flush to zero: no denormal results are produced.
          nxt_result = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
          nxt_flags  = '0;
          nxt_flags[FLG_UNDERFLOW] = 1'b1;
          nxt_flags[FLG_INEXACT]   = 1'b1;
        end
      end
    endcase
  end

  // Handshake: a stage may load when it is empty or its contents move on this cycle.
  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = rdy_q && (!s1_valid || s2_adv);
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_cls   <= CLS_NORMAL;
      s2_valid <= 1'b0;
      result   <= '0;
      flags    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= nxt_result;
          flags  <= nxt_flags;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= sign_a ^ sign_b;
          s1_exp  <= c1_exp;
          s1_frac <= c1_frac;
          s1_g    <= c1_g;
          s1_s    <= c1_s;
          s1_cls  <= resolve_class(cls_e'(class_a), cls_e'(class_b));
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_norm_round.sv
// tb/tb_mul_norm_round.sv - self-checking bench for mul_norm_round
module tb_mul_norm_round;
  import mul_fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] mant_prod = '0;
  logic [7:0]  exp_a = '0, exp_b = '0;
  logic        sign_a = 1'b0, sign_b = 1'b0;
  logic [1:0]  class_a = 2'b00, class_b = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mul_norm_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mant_prod(mant_prod), .exp_a(exp_a), .exp_b(exp_b),
    .sign_a(sign_a), .sign_b(sign_b), .class_a(class_a), .class_b(class_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  typedef struct {
    logic [7:0]  ea, eb;
    logic        sa, sb;
    logic [1:0]  ca, cb;
    logic [47:0] p;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference: value-level rounding on the integer product, remainder vs. half.
  function automatic logic [35:0] model(input logic [7:0] ea, input logic [7:0] eb,
                                        input logic sa, input logic sb,
                                        input logic [1:0] ca, input logic [1:0] cb,
                                        input logic [47:0] p);
    logic sign;
    bit any_nan, any_inf, any_zero, inexact;
    int e, sh;
    longint unsigned kept, rem, half, pv;
    sign = sa ^ sb;
    any_nan  = (ca == 2'd3) || (cb == 2'd3);
    any_inf  = (ca == 2'd2) || (cb == 2'd2);
    any_zero = (ca == 2'd1) || (cb == 2'd1);
    if (any_nan || (any_inf && any_zero)) return {4'b1000, 32'h7FC0_0000};
    if (any_inf) return {4'b0000, sign, 8'hFF, 23'd0};
    if (any_zero) return {4'b0000, sign, 31'd0};
    pv = {16'd0, p};
    sh = p[47] ? 24 : 23;
    e = int'(ea) + int'(eb) - 127 + (p[47] ? 1 : 0);
    kept = pv >> sh;
    rem  = pv & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    if (kept >= (64'd1 << 24)) begin
      kept = kept >> 1;
      e = e + 1;
    end
    inexact = (rem != 0);
    if (e >= 255) return {4'b0101, sign, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0011, sign, 31'd0};
    return {3'b000, inexact, sign, e[7:0], kept[22:0]};
  endfunction

  task automatic drive(input vec_t v);
    exp_a = v.ea; exp_b = v.eb; sign_a = v.sa; sign_b = v.sb;
    class_a = v.ca; class_b = v.cb; mant_prod = v.p;
  endtask

  // Present current inputs until accepted; returns at edge+1 of the accepting edge.
  task automatic accept(input string name);
    bit done;
    done = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check({name, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    drive(v);
    accept($sformatf("vec%0d", idx));
    if (idx == 0) check("latency_early", {63'd0, out_valid}, 64'd0);
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (idx == 0) check("latency", cyc, 64'd2);
    if (!out_valid) check($sformatf("vec%0d_out_timeout", idx), 64'd0, 64'd1);
    check($sformatf("vec%0d_result", idx), result, v.res);
    check($sformatf("vec%0d_flags", idx), flags, v.flg);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic [7:0] ea, input logic [7:0] eb, input logic sa,
                              input logic sb, input logic [1:0] ca, input logic [1:0] cb,
                              input logic [47:0] p, input logic [31:0] res, input logic [3:0] flg);
    vec_t v;
    v.ea = ea; v.eb = eb; v.sa = sa; v.sb = sb; v.ca = ca; v.cb = cb;
    v.p = p; v.res = res; v.flg = flg;
    return v;
  endfunction

  logic [31:0] got[$];
  logic [35:0] exp_q[$];

  initial begin
    vec_t va, vb, vc;
    logic [35:0] e;
    logic [63:0] r64;
    bit   pend, held_v, bad;
    logic [35:0] held;

    tbl.push_back(mk(127, 127, 0, 0, 0, 0, 48'h4000_0000_0000, 32'h3F80_0000, 4'h0));
    tbl.push_back(mk(127, 127, 0, 0, 0, 0, 48'h9000_0000_0000, 32'h4010_0000, 4'h0));
    tbl.push_back(mk(127, 127, 0, 0, 0, 0, 48'h4000_0040_0000, 32'h3F80_0000, 4'h1));
    tbl.push_back(mk(127, 127, 0, 0, 0, 0, 48'h4000_00C0_0000, 32'h3F80_0002, 4'h1));
    tbl.push_back(mk(254, 254, 0, 0, 0, 0, 48'h4000_0000_0000, 32'h7F80_0000, 4'h5));
    tbl.push_back(mk(1,   1,   0, 0, 0, 0, 48'h4000_0000_0000, 32'h0000_0000, 4'h3));
    tbl.push_back(mk(254, 254, 1, 0, 0, 0, 48'h4000_0000_0000, 32'hFF80_0000, 4'h5));
    tbl.push_back(mk(1,   1,   1, 0, 0, 0, 48'h4000_0000_0000, 32'h8000_0000, 4'h3));
    tbl.push_back(mk(127, 127, 0, 0, 2, 1, 48'h4000_0000_0000, 32'h7FC0_0000, 4'h8));
    tbl.push_back(mk(127, 127, 0, 1, 2, 0, 48'h4000_0000_0000, 32'hFF80_0000, 4'h0));
    tbl.push_back(mk(127, 127, 1, 0, 1, 0, 48'h4000_0000_0000, 32'h8000_0000, 4'h0));
    tbl.push_back(mk(127, 127, 0, 0, 3, 0, 48'h4000_0000_0000, 32'h7FC0_0000, 4'h8));
    tbl.push_back(mk(127, 127, 0, 0, 0, 0, 48'h7FFF_FFC0_0000, 32'h4000_0000, 4'h1));
    tbl.push_back(mk(254, 127, 0, 0, 0, 0, 48'h7FFF_FFC0_0000, 32'h7F80_0000, 4'h5));
    tbl.push_back(mk(254, 127, 0, 0, 0, 0, 48'h4000_0000_0000, 32'h7F00_0000, 4'h0));
    tbl.push_back(mk(1,   127, 0, 0, 0, 0, 48'h4000_0000_0000, 32'h0080_0000, 4'h0));
    tbl.push_back(mk(1,   126, 0, 0, 0, 0, 48'h4000_0000_0000, 32'h0000_0000, 4'h3));

    // Reset state
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_flags", flags, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_held", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    check("rst_in_ready_after", {63'd0, in_ready}, 64'd1);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Stall: two ops fill the pipe, third is refused
    va = tbl[0]; vb = tbl[1]; vc = tbl[3];
    out_ready = 1'b0;
    drive(va); accept("stall_a");
    drive(vb); accept("stall_b");
    drive(vc); in_valid = 1'b1; #1;
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
      check("stall_hold_result", result, va.res);
    end
    out_ready = 1'b1; #1;
    got.delete();
    for (int i = 0; i < 12 && got.size() < 3; i++) begin
      pend = in_valid && in_ready;
      if (out_valid) got.push_back(result);
      @(posedge clk); #1;
      if (pend) in_valid = 1'b0;
    end
    check("stall_count", got.size(), 64'd3);
    if (got.size() == 3) begin
      check("stall_order0", got[0], va.res);
      check("stall_order1", got[1], vb.res);
      check("stall_order2", got[2], vc.res);
    end
    in_valid = 1'b0;

    // Reset mid-stream
    out_ready = 1'b0;
    drive(va); accept("rst_a");
    drive(vb); accept("rst_b");
    #3; rst_n = 1'b0; #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_result", result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) bad = 1;
      @(posedge clk); #1;
    end
    check("midrst_no_stale", {63'd0, bad}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);

    // Random traffic against the model
    exp_q.delete();
    pend = 0; held_v = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!pend && $urandom_range(0, 3) != 0) begin
        exp_a = 8'($urandom_range(1, 254));
        exp_b = 8'($urandom_range(1, 254));
        sign_a = 1'($urandom_range(0, 1));
        sign_b = 1'($urandom_range(0, 1));
        class_a = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(0, 3));
        class_b = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(0, 3));
        r64 = {$urandom(), $urandom()};
        mant_prod = r64[47:0];
        if ($urandom_range(0, 3) == 0) mant_prod[21:0] = '0;
        if ($urandom_range(0, 1) == 1) mant_prod[47] = 1'b1;
        else mant_prod[47:46] = 2'b01;
        pend = 1;
      end
      in_valid = pend;
      #1;
      if (held_v) begin
        check("rand_stall_valid", {63'd0, out_valid}, 64'd1);
        check("rand_stall_stable", {flags, result}, held);
      end
      held_v = out_valid && !out_ready;
      held = {flags, result};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(exp_a, exp_b, sign_a, sign_b, class_a, class_b, mant_prod));
        pend = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand_unexpected_out", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rand_out", {flags, result}, e);
        end
      end
      @(posedge clk); #1;
      if (!pend) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        check("drain_out", {flags, result}, e);
      end
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
